// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage RISC-V pipeline: load-use stall, branch flush,
// M/W forwarding, data-memory wait freeze with watchdog, and saturating event counters.
module hazard_control_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             RegWriteE,
    input  logic [1:0]       ResultSrcE,
    input  logic             MemWriteE,
    input  logic             PCSrcE,
    input  logic             DMemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] LoadStallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [15:0]      TIMEOUT_L = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0]      WAIT_MAX  = 16'hFFFF;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [4:0]       rd_m_r;
    logic             reg_write_m_r;
    logic             mem_acc_m_r;
    logic [4:0]       rd_w_r;
    logic             reg_write_w_r;
    logic [15:0]      wait_cnt_r;
    logic [15:0]      wait_cnt_nxt_s;
    logic             mem_timeout_r;
    logic [CNT_W-1:0] load_stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic             mem_wait_s;
    logic             lw_stall_s;
    logic             load_e_s;

    // M has priority over W; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       rw_m,
        input logic [4:0] rd_w,
        input logic       rw_w
    );
        logic [1:0] sel;
        if (rw_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign load_e_s   = (ResultSrcE == 2'b01);
    assign mem_wait_s = mem_acc_m_r & ~DMemReadyM;
    assign lw_stall_s = load_e_s & (RdE != 5'd0) & ((Rs1D == RdE) | (Rs2D == RdE));

    assign StallE     = mem_wait_s;
    assign StallM     = mem_wait_s;
    assign StallF     = mem_wait_s | lw_stall_s;
    assign StallD     = mem_wait_s | lw_stall_s;
    assign FlushD     = ~mem_wait_s & PCSrcE;
    assign FlushE     = ~mem_wait_s & (lw_stall_s | PCSrcE);

    assign MemTimeout     = mem_timeout_r;
    assign LoadStallCount = load_stall_cnt_r;
    assign FlushCount     = flush_cnt_r;

    // Forwarding selects for both E-stage operands
    always_comb begin
        ForwardAE = fwd_sel(Rs1E, rd_m_r, reg_write_m_r, rd_w_r, reg_write_w_r);
        ForwardBE = fwd_sel(Rs2E, rd_m_r, reg_write_m_r, rd_w_r, reg_write_w_r);
    end

    // Next watchdog count: saturating run length of consecutive wait cycles
    always_comb begin
        wait_cnt_nxt_s = wait_cnt_r;
        if (!mem_wait_s) begin
            wait_cnt_nxt_s = 16'd0;
        end else if (wait_cnt_r != WAIT_MAX) begin
            wait_cnt_nxt_s = wait_cnt_r + 16'd1;
        end else begin
            wait_cnt_nxt_s = wait_cnt_r;
        end
    end

    // Shadow M/W pipeline; a wait holds M and pushes a bubble into W
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_m_r        <= 5'd0;
            reg_write_m_r <= 1'b0;
            mem_acc_m_r   <= 1'b0;
            rd_w_r        <= 5'd0;
            reg_write_w_r <= 1'b0;
        end else if (!mem_wait_s) begin
            rd_m_r        <= RdE;
            reg_write_m_r <= RegWriteE;
            mem_acc_m_r   <= load_e_s | MemWriteE;
            rd_w_r        <= rd_m_r;
            reg_write_w_r <= reg_write_m_r;
        end else begin
            reg_write_w_r <= 1'b0;
        end
    end

    // Watchdog counter and sticky timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_r    <= 16'd0;
            mem_timeout_r <= 1'b0;
        end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
            if (mem_wait_s && (wait_cnt_nxt_s >= TIMEOUT_L)) begin
                mem_timeout_r <= 1'b1;
            end else begin
                mem_timeout_r <= mem_timeout_r;
            end
        end
    end

    // Saturating event counters; events during a wait are re-evaluated once it drops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r      <= {CNT_W{1'b0}};
        end else begin
            if (lw_stall_s && !mem_wait_s && (load_stall_cnt_r != CNT_MAX)) begin
                load_stall_cnt_r <= load_stall_cnt_r + CNT_ONE;
            end else begin
                load_stall_cnt_r <= load_stall_cnt_r;
            end
            if (PCSrcE && !mem_wait_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

endmodule
